// File: rtl/bw_io_ddr_strobe_testmux_ctl.sv
// Per-lane DDR strobe source selector: functional, toggle, serial pattern or hold level,
// with glitch-free mode switching (drain current mode, idle gap, then enter new mode).
module bw_io_ddr_strobe_testmux_ctl #(
  parameter int NCH     = 4,
  parameter int PAT_W   = 8,
  parameter int GAP_CYC = 2,
  parameter bit INV_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             testmode_l,
  input  logic             mode_vld,
  input  logic [1:0]       mode_req,
  output logic             mode_ack,
  input  logic [PAT_W-1:0] pattern,
  input  logic [NCH-1:0]   strobe,
  output logic [NCH-1:0]   strobe_out,
  output logic [1:0]       active_mode,
  output logic             busy
);

  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_GAP} state_t;
  typedef enum logic [1:0] {M_FUNC, M_TOGGLE, M_PATTERN, M_HOLD} mode_t;

  state_t           state_q, state_n;
  mode_t            mode_q, mode_n, tgt_q, tgt_n, tgt_sel;
  logic [NCH-1:0]   raw_q, raw_n, run_raw;
  logic [IW-1:0]    idx_q, idx_n, idx_inc;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [GW-1:0]    gap_q, gap_n;
  logic             pend_q, pend_n, ack_q, ack_n;
  logic             accept, drain_done;
  logic [NCH-1:0]   out_q;

  // Handshake: requester holds mode_vld/mode_req until mode_ack pulses. A request is
  // accepted only in RUN with testmode_l=0, and not in the ack cycle itself, so a
  // requester that drops mode_vld one cycle after seeing ack is never acked twice.
  assign accept  = (state_q == S_RUN) && !testmode_l && mode_vld && !ack_q;
  assign idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  always_comb begin
    run_raw = raw_q;
    case (mode_q)
      M_FUNC:    run_raw = strobe;
      M_TOGGLE:  run_raw = ~raw_q;
      M_PATTERN: run_raw = {NCH{pat_q[idx_inc]}};
      M_HOLD:    run_raw = '1;
      default:   run_raw = raw_q;
    endcase
  end

  always_comb begin
    case (mode_q)
      M_TOGGLE:  drain_done = (raw_q == '0);
      M_PATTERN: drain_done = (idx_q == IDX_LAST);
      default:   drain_done = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    tgt_n   = tgt_q;
    raw_n   = raw_q;
    idx_n   = idx_q;
    pat_n   = pat_q;
    gap_n   = gap_q;
    pend_n  = pend_q;
    ack_n   = 1'b0;
    tgt_sel = testmode_l ? M_FUNC : (accept ? mode_t'(mode_req) : tgt_q);
    case (state_q)
      S_RUN: begin
        tgt_n = tgt_sel;
        raw_n = run_raw;
        if (mode_q == M_PATTERN) idx_n = idx_inc;
        if (tgt_sel == mode_q) begin
          ack_n = accept;
        end else begin
          state_n = S_DRAIN;
          pend_n  = accept;
        end
      end
      S_DRAIN: begin
        if (testmode_l) begin
          tgt_n  = M_FUNC;
          pend_n = 1'b0;
        end
        if (drain_done) begin
          state_n = S_GAP;
          gap_n   = '0;
          raw_n   = '0;
        end else begin
          raw_n = run_raw;
          if (mode_q == M_PATTERN) idx_n = idx_inc;
        end
      end
      S_GAP: begin
        if (testmode_l) begin
          tgt_n  = M_FUNC;
          pend_n = 1'b0;
        end
        raw_n = '0;
        if (gap_q == GAP_LAST) begin
          state_n = S_RUN;
          mode_n  = tgt_n;
          ack_n   = pend_n;
          pend_n  = 1'b0;
          // First RUN cycle of the new mode
          case (tgt_n)
            M_FUNC:    raw_n = strobe;
            M_PATTERN: begin
              raw_n = {NCH{pattern[0]}};
              pat_n = pattern;
              idx_n = '0;
            end
            default:   raw_n = '1;
          endcase
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= S_RUN;
      mode_q  <= M_FUNC;
      tgt_q   <= M_FUNC;
      raw_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      out_q   <= {NCH{INV_OUT}};
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      tgt_q   <= tgt_n;
      raw_q   <= raw_n;
      idx_q   <= idx_n;
      pat_q   <= pat_n;
      gap_q   <= gap_n;
      pend_q  <= pend_n;
      ack_q   <= ack_n;
      out_q   <= raw_n ^ {NCH{INV_OUT}};
    end
  end

  assign strobe_out  = out_q;
  assign mode_ack    = ack_q;
  assign active_mode = mode_q;
  assign busy        = (state_q != S_RUN);

endmodule

// File: tb/tb_bw_io_ddr_strobe_testmux_ctl.sv
// Directed bench for the strobe test mux: reset, functional pass-through, mode switches,
// same-mode ack, pattern drain, testmode override and reset during a switch.
module tb_bw_io_ddr_strobe_testmux_ctl;

  logic       clk;
  logic       rst_l;
  logic       testmode_l;
  logic       mode_vld;
  logic [1:0] mode_req;
  logic       mode_ack;
  logic [7:0] pattern;
  logic [3:0] strobe;
  logic [3:0] strobe_out;
  logic [1:0] active_mode;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Expected {strobe_out, busy, mode_ack} per cycle
  logic [5:0] exp_q[$];

  bw_io_ddr_strobe_testmux_ctl #(
    .NCH(4), .PAT_W(8), .GAP_CYC(2), .INV_OUT(1'b1)
  ) dut (
    .clk(clk), .rst_l(rst_l), .testmode_l(testmode_l), .mode_vld(mode_vld),
    .mode_req(mode_req), .mode_ack(mode_ack), .pattern(pattern), .strobe(strobe),
    .strobe_out(strobe_out), .active_mode(active_mode), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_q(input string tag);
    logic [5:0] e;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d].strobe_out", tag, n), 32'(strobe_out), 32'(e[5:2]));
      chk($sformatf("%s[%0d].busy", tag, n), 32'(busy), 32'(e[1]));
      chk($sformatf("%s[%0d].ack", tag, n), 32'(mode_ack), 32'(e[0]));
      n++;
    end
  endtask

  initial begin
    rst_l = 1'b0; testmode_l = 1'b1; mode_vld = 1'b0; mode_req = 2'd0;
    pattern = 8'h00; strobe = 4'h0;

    // T1 reset
    tick(); tick();
    chk("t1.strobe_out", 32'(strobe_out), 32'hF);
    chk("t1.active_mode", 32'(active_mode), 32'd0);
    chk("t1.busy", 32'(busy), 32'd0);
    chk("t1.ack", 32'(mode_ack), 32'd0);

    // T2 functional pass-through, inverted, one-cycle latency
    rst_l = 1'b1; strobe = 4'b1010;
    tick();
    chk("t2.so_a", 32'(strobe_out), 32'b0101);
    strobe = 4'b0011;
    tick();
    chk("t2.so_b", 32'(strobe_out), 32'b1100);

    // T3 FUNC -> TOGGLE: drain 1, gap 2, then 1,0,...; ack held-request not re-acked
    testmode_l = 1'b0; strobe = 4'h0; mode_vld = 1'b1; mode_req = 2'd1;
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'h0, 1'b0, 1'b1});
    exp_q.push_back({4'hF, 1'b0, 1'b0});
    run_q("t3");
    chk("t3.active_mode", 32'(active_mode), 32'd1);
    mode_vld = 1'b0;
    exp_q.push_back({4'h0, 1'b0, 1'b0});
    run_q("t3b");

    // T5 same-mode request: ack next cycle, no gap, toggle continues
    mode_vld = 1'b1; mode_req = 2'd1;
    exp_q.push_back({4'hF, 1'b0, 1'b1});
    exp_q.push_back({4'h0, 1'b0, 1'b0});
    run_q("t5");

    // T4 TOGGLE -> PATTERN (bit0 first of 1100_1010), then HOLD requested at idx 3
    mode_req = 2'd2; pattern = 8'b1100_1010;
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b0, 1'b1});
    exp_q.push_back({4'h0, 1'b0, 1'b0});
    run_q("t4a");
    chk("t4.active_mode", 32'(active_mode), 32'd2);
    mode_vld = 1'b0; pattern = 8'h00;
    exp_q.push_back({4'hF, 1'b0, 1'b0});
    exp_q.push_back({4'h0, 1'b0, 1'b0});
    run_q("t4b");
    mode_vld = 1'b1; mode_req = 2'd3;
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'h0, 1'b1, 1'b0});
    exp_q.push_back({4'h0, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    exp_q.push_back({4'h0, 1'b0, 1'b1});
    exp_q.push_back({4'h0, 1'b0, 1'b0});
    run_q("t4c");
    chk("t4.hold_mode", 32'(active_mode), 32'd3);
    mode_vld = 1'b0;

    // T6a HOLD -> PATTERN, testmode_l rises during gap: ends in FUNC, no ack
    mode_vld = 1'b1; mode_req = 2'd2;
    exp_q.push_back({4'h0, 1'b1, 1'b0});
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    run_q("t6a");
    testmode_l = 1'b1;
    exp_q.push_back({4'hF, 1'b1, 1'b0});
    run_q("t6b");
    strobe = 4'b0110;
    exp_q.push_back({4'b1001, 1'b0, 1'b0});
    exp_q.push_back({4'b1001, 1'b0, 1'b0});
    run_q("t6c");
    chk("t6.func_mode", 32'(active_mode), 32'd0);

    // T6b reset during DRAIN abandons the switch
    testmode_l = 1'b0; mode_req = 2'd3;
    exp_q.push_back({4'b1001, 1'b1, 1'b0});
    run_q("t6d");
    rst_l = 1'b0;
    exp_q.push_back({4'hF, 1'b0, 1'b0});
    run_q("t6e");
    chk("t6.rst_mode", 32'(active_mode), 32'd0);
    rst_l = 1'b1; mode_vld = 1'b0;
    exp_q.push_back({4'b1001, 1'b0, 1'b0});
    run_q("t6f");
    chk("t6.post_rst_mode", 32'(active_mode), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
